// File: rtl/esi_crypt_pkg.sv
// Shared types for the one-time-pad stream path: payload and key/mode structs,
// plus the decryptor key state.
package esi_crypt_pkg;

   localparam int BLOB_W = 256;

   typedef struct packed {
      logic [BLOB_W-1:0] blob;
      logic              encrypted;
   } data_t;

   typedef struct packed {
      logic [BLOB_W-1:0] otp;
      logic              encrypt;
   } cfg_t;

   typedef enum logic {
      NO_KEY = 1'b0,
      KEYED  = 1'b1
   } state_e;

endpackage

// File: rtl/esi_skid_fifo2.sv
// Generic 2-entry registered valid/ready buffer; one transfer per cycle in steady
// state, push_ready depends only on registered occupancy.
module esi_skid_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   assign push_ready = (count != 2'd2);
   assign pop_valid  = (count != 2'd0);
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;
   assign pop_data   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is never read before it is written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/esi_stream_decryptor.sv
// Receive side of the one-time-pad path: XORs flagged structs with the loaded pad,
// buffers results in a 2-entry FIFO and counts decrypted / passed-through structs.
//
//   state  | meaning
//   NO_KEY | no pad loaded yet; input is held off
//   KEYED  | pad and mode loaded; normal streaming
module esi_stream_decryptor #(
   parameter int BLOB_W = esi_crypt_pkg::BLOB_W,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  esi_crypt_pkg::data_t in_data,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  esi_crypt_pkg::cfg_t  cfg_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output esi_crypt_pkg::data_t out_data,
   output logic [CNT_W-1:0]     decCount,
   output logic [CNT_W-1:0]     passCount
);
   import esi_crypt_pkg::*;

   state_e            state;
   state_e            state_nx;
   logic [BLOB_W-1:0] otp;
   logic              mode_enc;
   logic              cfg_hs;
   logic              in_hs;
   logic              do_dec;
   logic              fifo_ready;
   data_t             xformed;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= NO_KEY;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cfg_ready = !out_valid;
      cfg_hs    = cfg_valid && cfg_ready;
      in_ready  = 1'b0;
      case (state)
         NO_KEY: if (cfg_hs) state_nx = KEYED;
         KEYED:  in_ready = fifo_ready && !cfg_hs;
         default: state_nx = NO_KEY;
      endcase
   end

   assign in_hs = in_valid && in_ready;

   // Key registers are only meaningful once KEYED, so they carry no reset.
   always_ff @(posedge clk) begin
      if (cfg_hs) begin
         otp      <= cfg_data.otp;
         mode_enc <= cfg_data.encrypt;
      end
   end

   always_comb begin
      xformed = in_data;
      do_dec  = mode_enc && in_data.encrypted;
      if (do_dec) begin
         xformed.blob      = in_data.blob ^ otp;
         xformed.encrypted = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         decCount  <= '0;
         passCount <= '0;
      end else if (in_hs) begin
         if (do_dec) decCount  <= decCount + CNT_W'(1);
         else        passCount <= passCount + CNT_W'(1);
      end
   end

   esi_skid_fifo2 #(
      .W($bits(data_t))
   ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_valid (in_hs),
      .push_ready (fifo_ready),
      .push_data  (xformed),
      .pop_valid  (out_valid),
      .pop_ready  (out_ready),
      .pop_data   (out_data)
   );

endmodule
